// File: rtl/cgra_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cgra_cfg_pkg
//  Purpose  : Shared types and constants for the CGRA configuration receiver:
//             the buffered config word layout, the no-op address and the
//             receiver state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cgra_cfg_pkg;

    // An all-zero address on the config stream carries no word.
    localparam logic [31:0] CFG_NOOP_ADDR = 32'h0000_0000;

    // One buffered config word. The reserved address byte is not stored.
    typedef struct packed {
        logic [7:0]  reg_id;
        logic [15:0] tile;
        logic [31:0] data;
    } cfg_word_t;

    // Receiver progress: nothing seen yet, stream active, stream finished.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } cfg_state_t;

endpackage : cgra_cfg_pkg
`default_nettype wire

// File: rtl/cfg_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_sync_fifo
//  Purpose  : Single-clock FIFO for config words. Exposes the head entry and
//             the entry behind it so the consumer can present the next word
//             on the same edge it retires the current one.
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_sync_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] head_data_out,
    output logic [WIDTH-1:0] next_data_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             multi_out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [AW:0]      w_level;
    logic [AW-1:0]    w_rd_idx;
    logic [AW-1:0]    w_next_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Status flags, gated push/pop and pointer advance. The extra pointer bit
    // separates a full FIFO from an empty one when the indices coincide.
    always_comb begin
        w_level    = wr_ptr_q - rd_ptr_q;
        w_empty    = (wr_ptr_q == rd_ptr_q);
        w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        w_pop      = pop_in && !w_empty;
        // A full FIFO still takes a word when an entry leaves on the same edge.
        w_push     = push_in && (!w_full || w_pop);
        w_rd_idx   = rd_ptr_q[AW-1:0];
        w_next_idx = w_rd_idx + AW'(1);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        head_data_out = mem_q[w_rd_idx];
        next_data_out = mem_q[w_next_idx];
        full_out      = w_full;
        empty_out     = w_empty;
        multi_out     = (w_level > (AW+1)'(1));
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_in;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule : cfg_sync_fifo
`default_nettype wire

// File: rtl/cgra_config_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : cgra_config_receiver
//  Purpose  : Accepts the chip config stream one word per clock, buffers it
//             and replays it onto the tile config bus with valid/ready.
//             Reports completion, a saturating word count and a sticky
//             overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module cgra_config_receiver
    import cgra_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [31:0]      config_addr_in,
    input  logic [31:0]      config_data_in,
    output logic [15:0]      cfg_tile_out,
    output logic [7:0]       cfg_reg_out,
    output logic [31:0]      cfg_data_out,
    output logic             cfg_valid_out,
    input  logic             cfg_ready_in,
    output logic             config_done_out,
    output logic [CNT_W-1:0] word_count_out,
    output logic             overflow_out
);

    localparam int              IW          = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);
    localparam logic [IW-1:0]   C_IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    cfg_word_t        w_push_word;
    cfg_word_t        w_head_word;
    cfg_word_t        w_next_word;
    cfg_word_t        word_q;
    cfg_word_t        word_d;
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] word_count_q;
    logic [CNT_W-1:0] word_count_d;
    logic             overflow_q;
    logic             overflow_d;
    cfg_state_t       state_q;
    cfg_state_t       state_d;
    logic [IW-1:0]    idle_cnt_q;
    logic [IW-1:0]    idle_cnt_d;
    logic             done_q;
    logic             done_d;

    logic             w_addr_nz;
    logic             w_xfer;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_multi;
    logic             w_idle;

    // Incoming word decode and push/drop decision. The presented word stays in
    // the FIFO until it is handed over, so a transfer frees a slot this edge.
    always_comb begin
        w_addr_nz          = (config_addr_in != CFG_NOOP_ADDR);
        w_xfer             = valid_q && cfg_ready_in;
        w_push             = w_addr_nz && (!w_full || w_xfer);
        w_push_word.reg_id = config_addr_in[31:24];
        w_push_word.tile   = config_addr_in[15:0];
        w_push_word.data   = config_data_in;
        w_idle             = !w_addr_nz && w_empty && !valid_q;
    end

    cfg_sync_fifo #(
        .WIDTH ($bits(cfg_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .push_in       (w_push),
        .push_data_in  (w_push_word),
        .pop_in        (w_xfer),
        .head_data_out (w_head_word),
        .next_data_out (w_next_word),
        .full_out      (w_full),
        .empty_out     (w_empty),
        .multi_out     (w_multi)
    );

    // Output register: mirrors the FIFO head one cycle late, and on a
    // transfer jumps straight to the following entry for back-to-back flow.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (w_xfer) begin
            valid_d = w_multi;
            if (w_multi) begin
                word_d = w_next_word;
            end
        end else if (!valid_q && !w_empty) begin
            valid_d = 1'b1;
            word_d  = w_head_word;
        end
    end

    // Saturating accepted-word counter and sticky drop flag.
    always_comb begin
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        if (w_push && (word_count_q != C_CNT_MAX)) begin
            word_count_d = word_count_q + CNT_W'(1);
        end
        if (w_addr_nz && !w_push) begin
            overflow_d = 1'b1;
        end
    end

    // Completion FSM: next state, idle run length and registered done flag.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (w_addr_nz) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (w_idle) begin
                    if (idle_cnt_q == C_IDLE_LAST) begin
                        state_d = DONE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end
            end
            DONE: begin
                if (w_addr_nz) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    // State, counters and output register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            word_q       <= '0;
            valid_q      <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            word_q       <= word_d;
            valid_q      <= valid_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        cfg_tile_out    = word_q.tile;
        cfg_reg_out     = word_q.reg_id;
        cfg_data_out    = word_q.data;
        cfg_valid_out   = valid_q;
        config_done_out = done_q;
        word_count_out  = word_count_q;
        overflow_out    = overflow_q;
    end

endmodule : cgra_config_receiver
`default_nettype wire

// File: tb/tb_cgra_config_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cgra_config_receiver
//  Purpose  : Self-checking bench for cgra_config_receiver. A queue-based
//             reference model tracks buffered words, presentation timing,
//             word count, overflow and completion.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cgra_config_receiver;

    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int CW    = 16;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b0;
    logic [31:0]   config_addr_in = '0;
    logic [31:0]   config_data_in = '0;
    logic          cfg_ready_in = 1'b0;
    logic [15:0]   cfg_tile_out;
    logic [7:0]    cfg_reg_out;
    logic [31:0]   cfg_data_out;
    logic          cfg_valid_out;
    logic          config_done_out;
    logic [CW-1:0] word_count_out;
    logic          overflow_out;

    cgra_config_receiver #(
        .FIFO_DEPTH   (DEPTH),
        .IDLE_TIMEOUT (TO),
        .CNT_W        (CW)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .config_addr_in  (config_addr_in),
        .config_data_in  (config_data_in),
        .cfg_tile_out    (cfg_tile_out),
        .cfg_reg_out     (cfg_reg_out),
        .cfg_data_out    (cfg_data_out),
        .cfg_valid_out   (cfg_valid_out),
        .cfg_ready_in    (cfg_ready_in),
        .config_done_out (config_done_out),
        .word_count_out  (word_count_out),
        .overflow_out    (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  r;
        logic [15:0] t;
        logic [31:0] d;
        int          pe;   // model edge number on which the word was accepted
    } mword_t;

    mword_t mq[$];
    int     edge_no   = 0;
    int     m_count   = 0;
    bit     m_ovf     = 1'b0;
    bit     m_started = 1'b0;
    bit     m_done    = 1'b0;
    int     m_run     = 0;
    int     n_cmp     = 0;
    int     n_bad     = 0;

    // A word is on the bus once it heads the queue and was accepted on an
    // earlier edge than the most recent one.
    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].pe < edge_no);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_count   = 0;
        m_ovf     = 1'b0;
        m_started = 1'b0;
        m_done    = 1'b0;
        m_run     = 0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bit     xfer;
        bit     was_full;
        mword_t w;
        xfer     = m_valid() && rdy;
        was_full = (mq.size() == DEPTH);
        if (a != 32'h0) begin
            m_started = 1'b1;
            m_done    = 1'b0;
            m_run     = 0;
        end else if (m_started && !m_done) begin
            if (mq.size() == 0) m_run++;
            else                m_run = 0;
            if (m_run == TO) begin
                m_done = 1'b1;
                m_run  = 0;
            end
        end
        if (xfer) void'(mq.pop_front());
        if (a != 32'h0) begin
            if (!was_full || xfer) begin
                w.r  = a[31:24];
                w.t  = a[15:0];
                w.d  = d;
                w.pe = edge_no + 1;
                mq.push_back(w);
                if (m_count < (1 << CW) - 1) m_count++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        edge_no++;
    endtask

    // Drive one clock of inputs; the model follows the edge when out of reset.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        config_addr_in = a;
        config_data_in = d;
        cfg_ready_in   = rdy;
        @(posedge clk_in);
        if (reset_in) model_edge(a, d, rdy);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        reset_in       = 1'b0;
        config_addr_in = '0;
        config_data_in = '0;
        cfg_ready_in   = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[15:0] = a[15:0] | 16'h0001;
        return a;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle($urandom, $urandom, 1'($urandom));
            n_cmp++; if (cfg_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cfg_valid_out); end
            n_cmp++; if ({cfg_tile_out, cfg_reg_out, cfg_data_out} !== 56'h0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", {cfg_tile_out, cfg_reg_out, cfg_data_out}); end
            n_cmp++; if ({config_done_out, overflow_out, word_count_out} !== '0) begin n_bad++; $display("FAIL reset_status: got %h want 0", {config_done_out, overflow_out, word_count_out}); end
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(32'h0, $urandom, 1'($urandom));
            n_cmp++; if (config_done_out !== 1'b0 || cfg_valid_out !== 1'b0 || word_count_out !== '0) begin
                n_bad++; $display("FAIL idle_after_reset: got done=%b valid=%b count=%0d want 0/0/0", config_done_out, cfg_valid_out, word_count_out);
            end
        end
    endtask

    task automatic test_single();
        int k;
        cycle(32'h0300_0017, 32'hDEAD_BEEF, 1'b1);
        n_cmp++; if (cfg_valid_out !== 1'b0) begin n_bad++; $display("FAIL single_early: got valid=%b want 0", cfg_valid_out); end
        cycle(32'h0, 32'h0, 1'b1);
        n_cmp++; if ({cfg_valid_out, cfg_tile_out, cfg_reg_out, cfg_data_out} !== {1'b1, 16'h0017, 8'h03, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL single_word: got v=%b t=%h r=%h d=%h want v=1 t=0017 r=03 d=deadbeef", cfg_valid_out, cfg_tile_out, cfg_reg_out, cfg_data_out);
        end
        cycle(32'h0, 32'h0, 1'b1);
        n_cmp++; if (cfg_valid_out !== 1'b0 || word_count_out !== 16'd1) begin
            n_bad++; $display("FAIL single_after: got valid=%b count=%0d want 0/1", cfg_valid_out, word_count_out);
        end
        k = 0;
        while (k < 20 && config_done_out !== 1'b1) begin
            k++;
            cycle(32'h0, 32'h0, 1'b1);
            n_cmp++; if (config_done_out !== m_done) begin n_bad++; $display("FAIL single_done_trace: got %b want %b", config_done_out, m_done); end
        end
        n_cmp++; if (k != TO) begin n_bad++; $display("FAIL single_timeout: got %0d idle clk want %0d", k, TO); end
    endtask

    task automatic test_backpressure();
        logic [31:0] wa [6];
        logic [31:0] wd [6];
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            wa[i] = rand_addr();
            wd[i] = $urandom;
            cycle(wa[i], wd[i], 1'b0);
        end
        n_cmp++; if (word_count_out !== 16'd4 || overflow_out !== 1'b1) begin
            n_bad++; $display("FAIL bp_status: got count=%0d ovf=%b want 4/1", word_count_out, overflow_out);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(32'h0, 32'h0, 1'b0);
            n_cmp++; if ({cfg_valid_out, cfg_tile_out, cfg_reg_out, cfg_data_out} !== {1'b1, wa[0][15:0], wa[0][31:24], wd[0]}) begin
                n_bad++; $display("FAIL bp_stall: got v=%b t=%h r=%h d=%h want t=%h r=%h d=%h", cfg_valid_out, cfg_tile_out, cfg_reg_out, cfg_data_out, wa[0][15:0], wa[0][31:24], wd[0]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({cfg_valid_out, cfg_tile_out, cfg_reg_out, cfg_data_out} !== {1'b1, wa[i][15:0], wa[i][31:24], wd[i]}) begin
                n_bad++; $display("FAIL bp_drain%0d: got v=%b t=%h d=%h want t=%h d=%h", i, cfg_valid_out, cfg_tile_out, cfg_data_out, wa[i][15:0], wd[i]);
            end
            cycle(32'h0, 32'h0, 1'b1);
        end
        n_cmp++; if (cfg_valid_out !== 1'b0 || overflow_out !== 1'b1) begin
            n_bad++; $display("FAIL bp_end: got valid=%b ovf=%b want 0/1", cfg_valid_out, overflow_out);
        end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] wa [5];
        logic [31:0] wd [5];
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            wa[i] = rand_addr();
            wd[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) cycle(wa[i], wd[i], 1'b0);
        cycle(wa[4], wd[4], 1'b1);
        n_cmp++; if (overflow_out !== 1'b0 || word_count_out !== 16'd5) begin
            n_bad++; $display("FAIL full_pushpop: got ovf=%b count=%0d want 0/5", overflow_out, word_count_out);
        end
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if ({cfg_valid_out, cfg_tile_out, cfg_data_out} !== {1'b1, wa[i][15:0], wd[i]}) begin
                n_bad++; $display("FAIL full_order%0d: got v=%b t=%h d=%h want t=%h d=%h", i, cfg_valid_out, cfg_tile_out, cfg_data_out, wa[i][15:0], wd[i]);
            end
            cycle(32'h0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_done_reentry();
        int k;
        k = 0;
        while (k < 30 && config_done_out !== 1'b1) begin
            k++;
            cycle(32'h0, 32'h0, 1'b1);
        end
        n_cmp++; if (config_done_out !== 1'b1) begin n_bad++; $display("FAIL reentry_first_done: got %b want 1", config_done_out); end
        cycle(32'h0100_0002, 32'h1234_5678, 1'b1);
        n_cmp++; if (config_done_out !== 1'b0) begin n_bad++; $display("FAIL reentry_drop: got %b want 0", config_done_out); end
        cycle(32'h0, 32'h0, 1'b1);
        n_cmp++; if ({cfg_valid_out, cfg_tile_out, cfg_reg_out, cfg_data_out} !== {1'b1, 16'h0002, 8'h01, 32'h1234_5678}) begin
            n_bad++; $display("FAIL reentry_word: got v=%b t=%h r=%h d=%h want v=1 t=0002 r=01 d=12345678", cfg_valid_out, cfg_tile_out, cfg_reg_out, cfg_data_out);
        end
        k = 0;
        while (k < 30 && config_done_out !== 1'b1) begin
            k++;
            cycle(32'h0, 32'h0, 1'b1);
            n_cmp++; if (config_done_out !== m_done) begin n_bad++; $display("FAIL reentry_trace: got %b want %b", config_done_out, m_done); end
        end
        n_cmp++; if (config_done_out !== 1'b1) begin n_bad++; $display("FAIL reentry_second_done: got %b want 1", config_done_out); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(rand_addr(), $urandom, 1'b0);
        cycle(32'h0, 32'h0, 1'b0);
        n_cmp++; if (cfg_valid_out !== 1'b1 || word_count_out !== 16'd3) begin
            n_bad++; $display("FAIL mid_pre: got valid=%b count=%0d want 1/3", cfg_valid_out, word_count_out);
        end
        #2;
        reset_in = 1'b0;
        #1;
        n_cmp++; if ({cfg_valid_out, overflow_out, config_done_out, word_count_out} !== '0) begin
            n_bad++; $display("FAIL mid_async: got valid=%b ovf=%b done=%b count=%0d want all 0", cfg_valid_out, overflow_out, config_done_out, word_count_out);
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(32'h0, 32'h0, 1'b1);
            n_cmp++; if (cfg_valid_out !== 1'b0 || word_count_out !== '0) begin
                n_bad++; $display("FAIL mid_stale: got valid=%b count=%0d want 0/0", cfg_valid_out, word_count_out);
            end
        end
    endtask

    task automatic test_random();
        int          phase;
        logic [31:0] a;
        logic        rdy;
        apply_reset();
        for (int i = 0; i < 480; i++) begin
            phase = (i / 40) % 3;
            case (phase)
                0:       begin a = ($urandom_range(0, 3) != 0) ? rand_addr() : 32'h0; rdy = ($urandom_range(0, 3) == 0); end
                1:       begin a = ($urandom_range(0, 2) == 0) ? rand_addr() : 32'h0; rdy = ($urandom_range(0, 3) != 0); end
                default: begin a = 32'h0; rdy = 1'($urandom); end
            endcase
            cycle(a, $urandom, rdy);
            n_cmp++; if (cfg_valid_out !== m_valid()) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, cfg_valid_out, m_valid()); end
            if (m_valid()) begin
                n_cmp++; if ({cfg_tile_out, cfg_reg_out, cfg_data_out} !== {mq[0].t, mq[0].r, mq[0].d}) begin
                    n_bad++; $display("FAIL rnd_word@%0d: got t=%h r=%h d=%h want t=%h r=%h d=%h", i, cfg_tile_out, cfg_reg_out, cfg_data_out, mq[0].t, mq[0].r, mq[0].d);
                end
            end
            n_cmp++; if (word_count_out !== CW'(m_count) || overflow_out !== m_ovf || config_done_out !== m_done) begin
                n_bad++; $display("FAIL rnd_status@%0d: got count=%0d ovf=%b done=%b want %0d/%b/%b", i, word_count_out, overflow_out, config_done_out, m_count, m_ovf, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_pushpop();
        test_done_reentry();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_cgra_config_receiver
`default_nettype wire
